// File: rtl/arcade_input_mapper_if.sv
// Host-side control bundle for the arcade input mapper: hps_io key/joystick
// words and option bits in, registered active-high player controls out.
interface arcade_input_mapper_if #(
  parameter int NUM_BTN = 2
);
  logic               ce;
  logic [64:0]        ps2_key;
  logic [15:0]        joystick_0;
  logic [15:0]        joystick_1;
  logic [1:0]         rotate;
  logic [1:0]         autofire_en;
  logic               coin_mode;
  logic [3:0]         p1_dir;
  logic [3:0]         p2_dir;
  logic [NUM_BTN-1:0] p1_btn;
  logic [NUM_BTN-1:0] p2_btn;
  logic [1:0]         start;
  logic [1:0]         coin;

  modport master (
    output ce, ps2_key, joystick_0, joystick_1, rotate, autofire_en, coin_mode,
    input  p1_dir, p2_dir, p1_btn, p2_btn, start, coin
  );

  modport slave (
    input  ce, ps2_key, joystick_0, joystick_1, rotate, autofire_en, coin_mode,
    output p1_dir, p2_dir, p1_btn, p2_btn, start, coin
  );
endinterface

// File: rtl/arcade_input_mapper.sv
// Two-player control mapper: PS/2 key latches merged with MiSTer joysticks,
// orientation rotation, btn0 autofire and a coin-pulse FSM per slot.
module arcade_input_player #(
  parameter int NUM_BTN  = 2,
  parameter int COIN_LEN = 16,
  parameter int COIN_GAP = 32
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               ce,
  input  logic [1:0]         rotate,
  input  logic               af_en,
  input  logic               af_phase,
  input  logic               coin_mode,
  input  logic [5+NUM_BTN:0] joy,
  input  logic [3:0]         kdir,
  input  logic [NUM_BTN-1:0] kbtn,
  input  logic               kstart,
  input  logic               kcoin,
  output logic [3:0]         dir,
  output logic [NUM_BTN-1:0] btn,
  output logic               start,
  output logic               coin
);
  typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_st_e;

  localparam logic [15:0] LEN_LD = 16'(COIN_LEN);
  localparam logic [15:0] GAP_LD = 16'(COIN_GAP);

  logic [3:0]         raw_dir, dir_d, dir_q;
  logic [NUM_BTN-1:0] raw_btn, btn_d, btn_q;
  logic               raw_start, raw_coin, req;
  logic               start_d, start_q;
  logic               coin_prev_d, coin_prev_q, start_prev_d, start_prev_q;
  coin_st_e           state_q;
  logic [15:0]        cnt_q;
  logic               pend_q, coin_q;

  always_comb begin
    raw_dir   = kdir | joy[3:0];
    raw_btn   = kbtn | joy[4 +: NUM_BTN];
    raw_start = kstart | joy[4+NUM_BTN];
    raw_coin  = kcoin | joy[5+NUM_BTN];
    // dir layout is {up,down,left,right}
    case (rotate)
      2'd1:    dir_d = {raw_dir[1], raw_dir[0], raw_dir[2], raw_dir[3]};
      2'd2:    dir_d = {raw_dir[0], raw_dir[1], raw_dir[3], raw_dir[2]};
      default: dir_d = raw_dir;
    endcase
    btn_d = raw_btn;
    if (af_en) btn_d[0] = raw_btn[0] & af_phase;
    start_d      = raw_start;
    coin_prev_d  = raw_coin;
    start_prev_d = raw_start;
    req = (raw_coin & ~coin_prev_q) | (~coin_mode & raw_start & ~start_prev_q);
  end

  // Edge trackers come out of reset high so a source already held during
  // reset is not mistaken for a fresh press.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dir_q        <= '0;
      btn_q        <= '0;
      start_q      <= 1'b0;
      coin_prev_q  <= 1'b1;
      start_prev_q <= 1'b1;
    end else begin
      dir_q        <= dir_d;
      btn_q        <= btn_d;
      start_q      <= start_d;
      coin_prev_q  <= coin_prev_d;
      start_prev_q <= start_prev_d;
    end
  end

  // coin_q tracks the registered state so the pulse covers every ce tick
  // spent in PULSE; a request arriving on an expiry cycle is never dropped.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      coin_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          state_q <= PULSE;
          cnt_q   <= LEN_LD;
          coin_q  <= 1'b1;
        end
        PULSE: begin
          if (ce && cnt_q == 16'd1) begin
            if (COIN_GAP != 0) begin
              state_q <= GAP;
              cnt_q   <= GAP_LD;
              coin_q  <= 1'b0;
              pend_q  <= pend_q | req;
            end else if (pend_q || req) begin
              cnt_q  <= LEN_LD;
              pend_q <= pend_q & req;
            end else begin
              state_q <= IDLE;
              cnt_q   <= '0;
              coin_q  <= 1'b0;
            end
          end else begin
            if (ce) cnt_q <= cnt_q - 16'd1;
            if (req) pend_q <= 1'b1;
          end
        end
        GAP: begin
          if (ce && cnt_q == 16'd1) begin
            if (pend_q || req) begin
              state_q <= PULSE;
              cnt_q   <= LEN_LD;
              coin_q  <= 1'b1;
              pend_q  <= pend_q & req;
            end else begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end else begin
            if (ce) cnt_q <= cnt_q - 16'd1;
            if (req) pend_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          coin_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dir   = dir_q;
  assign btn   = btn_q;
  assign start = start_q;
  assign coin  = coin_q;
endmodule

module arcade_input_mapper #(
  parameter int NUM_BTN  = 2,
  parameter int COIN_LEN = 16,
  parameter int COIN_GAP = 32,
  parameter int AF_HALF  = 4
) (
  input logic             clk_sys,
  input logic             reset_n,
  arcade_input_mapper_if.slave io
);
  localparam int B1 = (NUM_BTN >= 2) ? 1 : 0;

  logic                    old_tog_d, old_tog_q;
  logic [1:0][3:0]         kdir_d, kdir_q;
  logic [1:0][NUM_BTN-1:0] kbtn_d, kbtn_q;
  logic [1:0]              kstart_d, kstart_q, kcoin_d, kcoin_q;
  logic [7:0]              af_cnt_d, af_cnt_q;
  logic                    af_phase_d, af_phase_q;
  logic                    key_evt, key_dn;
  logic [1:0][15:0]        joy;
  logic [1:0][3:0]         dir;
  logic [1:0][NUM_BTN-1:0] btn;
  logic [1:0]              start, coin;
  logic                    unused_bits;

  assign joy         = {io.joystick_1, io.joystick_0};
  assign unused_bits = ^{io.ps2_key[23:16], joy};

  always_comb begin
    old_tog_d  = io.ps2_key[64];
    kdir_d     = kdir_q;
    kbtn_d     = kbtn_q;
    kstart_d   = kstart_q;
    kcoin_d    = kcoin_q;
    af_cnt_d   = af_cnt_q;
    af_phase_d = af_phase_q;
    key_dn  = io.ps2_key[15:8] != 8'hF0;
    key_evt = (io.ps2_key[64] != old_tog_q) && (io.ps2_key[63:24] == '0);
    if (key_evt) begin
      case (io.ps2_key[7:0])
        8'h75:        kdir_d[0][3] = key_dn;
        8'h72:        kdir_d[0][2] = key_dn;
        8'h6B:        kdir_d[0][1] = key_dn;
        8'h74:        kdir_d[0][0] = key_dn;
        8'h29, 8'h14: kbtn_d[0][0] = key_dn;
        8'h11:        if (NUM_BTN >= 2) kbtn_d[0][B1] = key_dn;
        8'h05:        kstart_d[0]  = key_dn;
        8'h2E:        kcoin_d[0]   = key_dn;
        8'h2D:        kdir_d[1][3] = key_dn;
        8'h2B:        kdir_d[1][2] = key_dn;
        8'h23:        kdir_d[1][1] = key_dn;
        8'h34:        kdir_d[1][0] = key_dn;
        8'h1C:        kbtn_d[1][0] = key_dn;
        8'h06:        kstart_d[1]  = key_dn;
        8'h36:        kcoin_d[1]   = key_dn;
        default: ;
      endcase
    end
    if (io.ce) begin
      if (af_cnt_q == 8'(AF_HALF - 1)) begin
        af_cnt_d   = '0;
        af_phase_d = ~af_phase_q;
      end else begin
        af_cnt_d = af_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      old_tog_q  <= 1'b0;
      kdir_q     <= '0;
      kbtn_q     <= '0;
      kstart_q   <= '0;
      kcoin_q    <= '0;
      af_cnt_q   <= '0;
      af_phase_q <= 1'b1;
    end else begin
      old_tog_q  <= old_tog_d;
      kdir_q     <= kdir_d;
      kbtn_q     <= kbtn_d;
      kstart_q   <= kstart_d;
      kcoin_q    <= kcoin_d;
      af_cnt_q   <= af_cnt_d;
      af_phase_q <= af_phase_d;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_pl
    arcade_input_player #(
      .NUM_BTN (NUM_BTN),
      .COIN_LEN(COIN_LEN),
      .COIN_GAP(COIN_GAP)
    ) u_pl (
      .clk_sys  (clk_sys),
      .reset_n  (reset_n),
      .ce       (io.ce),
      .rotate   (io.rotate),
      .af_en    (io.autofire_en[p]),
      .af_phase (af_phase_q),
      .coin_mode(io.coin_mode),
      .joy      (joy[p][5+NUM_BTN:0]),
      .kdir     (kdir_q[p]),
      .kbtn     (kbtn_q[p]),
      .kstart   (kstart_q[p]),
      .kcoin    (kcoin_q[p]),
      .dir      (dir[p]),
      .btn      (btn[p]),
      .start    (start[p]),
      .coin     (coin[p])
    );
  end

  assign io.p1_dir = dir[0];
  assign io.p2_dir = dir[1];
  assign io.p1_btn = btn[0];
  assign io.p2_btn = btn[1];
  assign io.start  = start;
  assign io.coin   = coin;
endmodule

// File: tb/tb_arcade_input_mapper.sv
// Scoreboard bench for arcade_input_mapper: timed output expectations and
// expected coin pulses are queued by the stimulus and retired by monitors.
module tb_arcade_input_mapper;
  localparam int NB = 2, CL = 16, CG = 32, AH = 4;
  localparam int S_P1D = 0, S_P2D = 1, S_P1B = 2, S_P2B = 3, S_ST = 4, S_CN = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tog = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;

  arcade_input_mapper_if #(.NUM_BTN(NB)) io();

  arcade_input_mapper #(
    .NUM_BTN(NB), .COIN_LEN(CL), .COIN_GAP(CG), .AF_HALF(AH)
  ) dut (
    .clk_sys(clk),
    .reset_n(rst_n),
    .io     (io)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; int sel; logic [31:0] exp; string nm; } chk_t;
  typedef struct { int slot; int ticks; int gap; } pulse_t;
  chk_t   chq[$];
  pulse_t pq[$];

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] get_out(int sel);
    case (sel)
      S_P1D:   return 32'(io.p1_dir);
      S_P2D:   return 32'(io.p2_dir);
      S_P1B:   return 32'(io.p1_btn);
      S_P2B:   return 32'(io.p2_btn);
      S_ST:    return 32'(io.start);
      default: return 32'(io.coin);
    endcase
  endfunction

  task automatic expect_out(int sel, logic [31:0] exp, int lat, string nm);
    chk_t c;
    c.due = cyc + lat; c.sel = sel; c.exp = exp; c.nm = nm;
    chq.push_back(c);
  endtask

  task automatic expect_pulse(int slot, int gap);
    pulse_t p;
    p.slot = slot; p.ticks = CL; p.gap = gap;
    pq.push_back(p);
  endtask

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic key(logic [7:0] code, bit rel, bit ign, bit ext);
    logic [7:0] hi;
    hi  = rel ? 8'hF0 : (ext ? 8'hE0 : 8'h00);
    tog = ~tog;
    io.ps2_key = {tog, (ign ? 40'h1 : 40'h0), 8'h00, hi, code};
  endtask

  // Timed output checks
  always @(negedge clk) begin
    while (chq.size() > 0 && chq[0].due <= cyc) begin
      chk_t c;
      c = chq.pop_front();
      cmp(c.nm, get_out(c.sel), c.exp);
    end
  end

  // Coin pulse monitor: measures high time and preceding low time in ce ticks
  int w[2], tk[2], lowtk[2], gapv[2];
  bit inp[2], seen[2];

  task automatic check_pulse(int s);
    int idx;
    idx = -1;
    for (int i = 0; i < pq.size(); i++)
      if (idx < 0 && pq[i].slot == s) idx = i;
    n_cmp++;
    if (idx < 0) begin
      n_bad++;
      $display("FAIL coin_unexpected slot%0d: got pulse of %0d ticks, want none", s, tk[s]);
    end else begin
      cmp($sformatf("coin_ticks%0d", s), tk[s], pq[idx].ticks);
      cmp($sformatf("coin_width%0d", s), (w[s] >= CL*4-3 && w[s] <= CL*4+1), 1);
      if (pq[idx].gap >= 0) cmp($sformatf("coin_gap%0d", s), gapv[s], pq[idx].gap);
      pq.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin inp[s] = 0; seen[s] = 0; lowtk[s] = 0; end
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (io.coin[s]) begin
          if (!inp[s]) begin
            inp[s] = 1; w[s] = 0; tk[s] = 0;
            gapv[s] = seen[s] ? lowtk[s] : -1;
          end
          w[s]++;
          if (io.ce) tk[s]++;
        end else begin
          if (inp[s]) begin
            inp[s] = 0; check_pulse(s); seen[s] = 1; lowtk[s] = 0;
          end
          if (io.ce) lowtk[s]++;
        end
      end
    end
  end

  // Autofire monitor: each full run of p1_btn[0] must last AF_HALF ce ticks
  bit af_on = 0, af_first = 0, af_seen = 0;
  int af_cnt = 0, af_tog = 0;
  logic af_last;
  always @(negedge clk) begin
    if (af_on) begin
      if (af_first) begin
        af_first = 0; af_last = io.p1_btn[0]; af_cnt = 0; af_seen = 0;
      end else if (io.p1_btn[0] !== af_last) begin
        if (af_seen) cmp("af_run", af_cnt, AH);
        af_seen = 1; af_tog++; af_cnt = 0; af_last = io.p1_btn[0];
      end
      if (io.ce) af_cnt++;
    end
  end

  // ce: one cycle in four
  initial begin
    int d;
    d = 0;
    io.ce = 1'b0;
    forever begin
      @(posedge clk); #1;
      io.ce = (d == 3);
      d = (d + 1) % 4;
    end
  end

  initial begin
    io.ps2_key = '0; io.joystick_0 = 16'h00FF; io.joystick_1 = 16'h00FF;
    io.rotate = 2'd0; io.autofire_en = 2'b00; io.coin_mode = 1'b0;
    tick(3);
    cmp("rst_p1_dir", io.p1_dir, 0);
    cmp("rst_p2_dir", io.p2_dir, 0);
    cmp("rst_p1_btn", io.p1_btn, 0);
    cmp("rst_p2_btn", io.p2_btn, 0);
    cmp("rst_start", io.start, 0);
    cmp("rst_coin", io.coin, 0);
    io.joystick_0 = '0; io.joystick_1 = '0;
    tick(1);
    rst_n = 1'b1;
    tick(2);

    // Keyboard events, latency, ignore/extended handling
    key(8'h75, 0, 0, 0); expect_out(S_P1D, 0, 1, "key_lat1"); expect_out(S_P1D, 4'h8, 2, "key_up");
    tick(4);
    key(8'h75, 1, 1, 0); expect_out(S_P1D, 4'h8, 2, "key_ignored");
    tick(4);
    key(8'h75, 1, 0, 0); expect_out(S_P1D, 4'h0, 2, "key_release");
    tick(4);
    key(8'h34, 0, 0, 1); expect_out(S_P2D, 4'h1, 2, "key_p2_right_ext");
    tick(4);
    key(8'h34, 1, 0, 0); tick(1);
    key(8'h2B, 0, 0, 0); expect_out(S_P2D, 4'h4, 2, "key_p2_down");
    tick(4);
    key(8'h2B, 1, 0, 0); tick(1);
    key(8'h1A, 0, 0, 0); expect_out(S_P1D, 4'h0, 2, "key_unlisted_p1"); expect_out(S_P2D, 4'h0, 2, "key_unlisted_p2");
    tick(4);

    // Rotation
    io.rotate = 2'd1; io.joystick_0 = 16'h0002; expect_out(S_P1D, 4'h8, 1, "rot1_left");
    tick(2);
    io.rotate = 2'd2; expect_out(S_P1D, 4'h4, 1, "rot2_left");
    tick(2);
    io.rotate = 2'd3; expect_out(S_P1D, 4'h2, 1, "rot3_left");
    tick(2);
    io.rotate = 2'd1; io.joystick_0 = 16'h0001; expect_out(S_P1D, 4'h4, 1, "rot1_right");
    tick(2);
    io.rotate = 2'd2; expect_out(S_P1D, 4'h8, 1, "rot2_right");
    tick(2);
    io.rotate = 2'd0; io.joystick_0 = 16'h0000; expect_out(S_P1D, 4'h0, 1, "rot0_idle");
    tick(4);

    // Start inserts coin when coin_mode=0
    expect_pulse(0, -1);
    io.joystick_0 = 16'h0040; expect_out(S_ST, 2'b01, 1, "start_p1"); expect_out(S_CN, 2'b01, 10, "coin_on");
    tick(20);
    io.joystick_0 = 16'h0000; expect_out(S_ST, 2'b00, 1, "start_p1_off");
    tick(250);

    // coin_mode=1: start alone never inserts a coin
    io.coin_mode = 1'b1;
    io.joystick_1 = 16'h0040; expect_out(S_ST, 2'b10, 1, "start_p2"); expect_out(S_CN, 2'b00, 6, "mode1_no_coin");
    tick(10);
    io.joystick_1 = 16'h0000;
    tick(10);

    // Pending depth one: two requests during GAP yield one extra pulse
    expect_pulse(0, -1); expect_pulse(1, -1); expect_pulse(0, CG);
    key(8'h2E, 0, 0, 0); io.joystick_1 = 16'h0080;
    tick(4);
    key(8'h2E, 1, 0, 0); io.joystick_1 = 16'h0000;
    tick(76);
    key(8'h2E, 0, 0, 0); tick(4); key(8'h2E, 1, 0, 0);
    tick(16);
    key(8'h2E, 0, 0, 0); tick(4); key(8'h2E, 1, 0, 0);
    tick(300);

    // Autofire on P1 btn0, P2 btn0 steady
    io.autofire_en = 2'b01;
    key(8'h29, 0, 0, 0); tick(2);
    key(8'h1C, 0, 0, 0); tick(4);
    af_tog = 0; af_first = 1; af_on = 1;
    for (int i = 0; i < 8; i++) begin
      expect_out(S_P2B, 2'b01, 1, "af_p2_steady");
      tick(12);
    end
    af_on = 0;
    cmp("af_toggles", af_tog >= 4, 1);
    key(8'h29, 1, 0, 0); tick(1);
    key(8'h1C, 1, 0, 0); io.autofire_en = 2'b00; expect_out(S_P2B, 2'b00, 2, "p2_btn_rel");
    tick(3);
    key(8'h14, 0, 0, 0); expect_out(S_P1B, 2'b01, 2, "p1_btn0_alt");
    tick(3);
    key(8'h11, 0, 0, 0); expect_out(S_P1B, 2'b11, 2, "p1_btn1");
    tick(3);
    key(8'h14, 1, 0, 0); expect_out(S_P1B, 2'b10, 2, "p1_btn0_rel");
    tick(3);
    key(8'h11, 1, 0, 0); tick(3);
    io.joystick_0 = 16'h0020; expect_out(S_P1B, 2'b10, 1, "p1_btn1_joy");
    tick(2);
    io.joystick_0 = 16'h0000;
    tick(4);

    // Reset mid-pulse, then held start must not re-trigger
    io.coin_mode = 1'b0;
    io.joystick_0 = 16'h0040;
    tick(20);
    cmp("coin_before_rst", io.coin, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    cmp("arst_coin", io.coin, 0);
    cmp("arst_start", io.start, 0);
    cmp("arst_p1_dir", io.p1_dir, 0);
    cmp("arst_p1_btn", io.p1_btn, 0);
    tick(3);
    rst_n = 1'b1;
    expect_out(S_ST, 2'b01, 1, "start_after_rst"); expect_out(S_CN, 2'b00, 3, "no_coin_held_a");
    expect_out(S_CN, 2'b00, 40, "no_coin_held_b");
    tick(150);
    io.joystick_0 = 16'h0000;
    tick(2);
    expect_pulse(0, -1);
    io.joystick_0 = 16'h0040;
    tick(80);
    io.joystick_0 = 16'h0000;
    tick(10);

    cmp("pulses_left", pq.size(), 0);
    cmp("checks_left", chq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
